// File: rtl/vc_switch_param.sv
// Parametrised virtual-channel switch: per-channel FIFOs, hysteresis pause, sticky overflow.
// Optional popped-word counters with req/idx readout are enabled by defining VC_COUNTERS_EN.
module vc_switch_param #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 12,
    parameter int DEPTH  = 8,
    parameter int UMB_W  = 8,
    parameter int CNT_W  = 5,
    parameter int IDX_W  = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     init,
    input  logic [UMB_W-1:0]         umbral_LH,
    input  logic                     push,
    input  logic [DATA_W-1:0]        data_in,
    input  logic [NUM_CH-1:0]        pop,
    output logic [NUM_CH*DATA_W-1:0] data_out,
    output logic [NUM_CH-1:0]        valid_out,
    output logic [NUM_CH-1:0]        empty,
    output logic [NUM_CH-1:0]        full,
    output logic [NUM_CH-1:0]        pause,
    output logic                     error,
    output logic [2:0]               state,
    input  logic                     req,
    input  logic [IDX_W-1:0]         idx,
    output logic [CNT_W-1:0]         cnt_out,
    output logic                     cnt_valid
);

    localparam int DW = $clog2(NUM_CH);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;
    localparam int HW = UMB_W / 2;
    localparam int CW = (OW > HW) ? OW : HW;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t st;

    logic [DATA_W-1:0] mem [NUM_CH][DEPTH];
    logic [PW-1:0]     wr_ptr [NUM_CH];
    logic [PW-1:0]     rd_ptr [NUM_CH];
    logic [OW-1:0]     occ [NUM_CH];
    logic [OW-1:0]     occ_nxt [NUM_CH];
    logic [HW-1:0]     thr_hi;
    logic [HW-1:0]     thr_lo;

    logic [DW-1:0]     dest;
    logic              push_ok;
    logic              pop_en;
    logic [NUM_CH-1:0] pop_acc;
    logic [NUM_CH-1:0] wr_acc;
    logic [NUM_CH-1:0] pause_nxt;
    logic              ovf;

    assign dest    = data_in[DATA_W-1 -: DW];
    assign push_ok = push && (st == S_IDLE || st == S_ACTIVE);
    assign pop_en  = (st == S_IDLE || st == S_ACTIVE || st == S_ERROR);
    assign state   = st;

    always_comb begin
        pop_acc   = '0;
        wr_acc    = '0;
        ovf       = 1'b0;
        pause_nxt = pause;
        for (int c = 0; c < NUM_CH; c++) begin
            empty[c]   = (occ[c] == '0);
            full[c]    = (occ[c] == OW'(DEPTH));
            pop_acc[c] = pop_en && pop[c] && !empty[c];
            // a full channel still accepts a push when it is popped the same cycle
            if (push_ok && dest == DW'(c)) begin
                if (!full[c] || pop_acc[c])
                    wr_acc[c] = 1'b1;
                else
                    ovf = 1'b1;
            end
            occ_nxt[c] = occ[c] + OW'(wr_acc[c]) - OW'(pop_acc[c]);
            if (thr_hi == '0)
                pause_nxt[c] = 1'b0;
            else if (thr_lo >= thr_hi)
                pause_nxt[c] = (CW'(occ_nxt[c]) >= CW'(thr_hi));
            else if (CW'(occ_nxt[c]) >= CW'(thr_hi))
                pause_nxt[c] = 1'b1;
            else if (CW'(occ_nxt[c]) <= CW'(thr_lo))
                pause_nxt[c] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st     <= S_RESET;
            thr_hi <= '0;
            thr_lo <= '0;
            error  <= 1'b0;
        end else begin
            error <= error | ovf;
            unique case (st)
                S_RESET: st <= S_INIT;
                S_INIT: begin
                    thr_hi <= umbral_LH[UMB_W-1:HW];
                    thr_lo <= umbral_LH[HW-1:0];
                    if (!init)
                        st <= S_IDLE;
                end
                S_IDLE: begin
                    if (ovf)
                        st <= S_ERROR;
                    else if (push)
                        st <= S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (ovf)
                        st <= S_ERROR;
                    else if ((&empty) && !push)
                        st <= S_IDLE;
                end
                S_ERROR: st <= S_ERROR;
                default: st <= S_RESET;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_acc[c])
                mem[c][wr_ptr[c]] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out  <= '0;
            valid_out <= '0;
            pause     <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                occ[c]    <= '0;
            end
        end else begin
            valid_out <= pop_acc;
            pause     <= pause_nxt;
            for (int c = 0; c < NUM_CH; c++) begin
                occ[c] <= occ_nxt[c];
                if (wr_acc[c])
                    wr_ptr[c] <= wr_ptr[c] + 1'b1;
                if (pop_acc[c]) begin
                    data_out[c*DATA_W +: DATA_W] <= mem[c][rd_ptr[c]];
                    rd_ptr[c] <= rd_ptr[c] + 1'b1;
                end
            end
        end
    end

`ifdef VC_COUNTERS_EN
    logic [CNT_W-1:0] cnt [NUM_CH];

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_out   <= '0;
            cnt_valid <= 1'b0;
            for (int c = 0; c < NUM_CH; c++)
                cnt[c] <= '0;
        end else begin
            cnt_valid <= req;
            if (req)
                cnt_out <= (idx < IDX_W'(NUM_CH)) ? cnt[idx[DW-1:0]] : '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (pop_acc[c] && cnt[c] != '1)
                    cnt[c] <= cnt[c] + 1'b1;
            end
        end
    end
`else
    logic unused_cnt;

    assign unused_cnt = ^{req, idx};
    assign cnt_out    = '0;
    assign cnt_valid  = 1'b0;
`endif

endmodule
